v_issue_queue: RTL
==================

V_ISSUE_QUEUE -- requirements
Module: v_issue_queue

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, the number of queue entries (power of two, at least 2).
REQ-002 SHALL provide parameter WORD_WIDTH, default 32, the instruction and scalar-operand width.
REQ-003 SHALL provide port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL provide port in_valid, input, 1 bit: the scalar core presents a vector instruction.
REQ-006 SHALL provide port in_instr, input, WORD_WIDTH bits: the vector instruction word.
REQ-007 SHALL provide port in_scalar, input, WORD_WIDTH bits: the scalar register operand (rs1 value) captured with the instruction.
REQ-008 SHALL provide port in_ready, output, 1 bit: the queue can accept an entry.
REQ-009 SHALL provide port out_valid, output, 1 bit: the head entry is available to the vector coprocessor.
REQ-010 SHALL provide port out_instr, output, WORD_WIDTH bits: the head instruction.
REQ-011 SHALL provide port out_scalar, output, WORD_WIDTH bits: the head scalar operand.
REQ-012 SHALL provide port out_ready, input, 1 bit: the coprocessor accepts the head entry.
REQ-013 SHALL provide port flush, input, 1 bit: discard all queued entries.
REQ-014 SHALL provide port count, output, log2(DEPTH)+1 bits: the current occupancy.
REQ-015 SHALL provide port illegal_instr, output, 1 bit: a one-cycle pulse flagging a rejected instruction.
REQ-016 SHALL provide port issued_cnt, output, 16 bits: the total number of entries popped.

Function
REQ-017 SHALL treat in_instr as legal only if in_instr[6:0] is 7'h57 (OP-V), 7'h07 (LOAD-FP) or 7'h27 (STORE-FP).
REQ-018 SHALL define push = in_valid & in_ready & legal, and pop = out_valid & out_ready.
REQ-019 SHALL set in_ready = (count < DEPTH), registered-state-derived only, with no combinational path from out_ready or in_valid.
REQ-020 SHALL set out_valid = (count != 0), and SHALL drive out_instr and out_scalar from the head entry (first-word fall-through); both SHALL be 0 when empty.
REQ-021 SHALL make a pushed entry visible on out_* in the cycle after the push edge; push-to-out_valid latency is 1 cycle, and there is no same-cycle bypass.
REQ-022 SHALL increment the write pointer on push and the read pointer on pop, each modulo DEPTH (wrap-around).
REQ-023 SHALL update count as follows: push only, +1; pop only, -1; push and pop together, unchanged.
REQ-024 SHALL, when full (count = DEPTH), hold in_ready = 0, so that no push occurs even if pop is asserted the same cycle.
REQ-025 SHALL, when empty, ignore out_ready (no pop, no pointer change).
REQ-026 SHALL, when in_valid & in_ready & !legal, not enqueue the entry and assert illegal_instr for exactly that cycle +1 (registered pulse); when in_ready = 0, no illegal check or pulse occurs.
REQ-027 SHALL, when flush = 1, set count, both pointers, and out_valid to 0 at the next edge; flush overrides push and pop in the same cycle, and no illegal_instr pulse results.
REQ-028 SHALL increment issued_cnt by 1 per pop, wrapping from 16'hFFFF to 0; flush does not clear it.
REQ-029 SHALL preserve FIFO order and leave entry contents unchanged while queued.

Reset
REQ-030 SHALL, on rst = 1 at a clock edge, set count = 0, pointers = 0, out_valid = 0, out_instr = 0, out_scalar = 0, illegal_instr = 0, issued_cnt = 0, and in_ready = 1 after that edge.
REQ-031 SHALL give rst priority over flush, push and pop, discarding any in-flight entries on reset mid-operation.

Verification
REQ-032 Fill/drain: push 4 OP-V words 0x00000057, 0x01000057, 0x02000057, 0x03000057 with out_ready = 0 -> count = 4, in_ready = 0; then out_ready = 1 -> pops in the same order over 4 cycles, issued_cnt = 4.
REQ-033 Simultaneous push/pop at count = 2 -> count stays 2, order preserved; at count = 4 with out_ready = 1 -> pop only, count = 3.
REQ-034 Illegal instruction: push 0x00000033 -> illegal_instr = 1 for one cycle, count unchanged, out_valid unchanged.
REQ-035 Flush together with push and pop at count = 3 -> next cycle count = 0, out_valid = 0, out_instr = 0, issued_cnt unchanged.
REQ-036 Wrap-around: run 10 push/pop pairs -> pointers wrap and data matches, including in_scalar = 0xDEADBEEF carried intact.
REQ-037 Reset mid-operation: rst at count = 3 -> next cycle count = 0, out_valid = 0, issued_cnt = 0, in_ready = 1.

Source files
------------

// File: rtl/v_issue_queue.sv
// Instruction issue queue between the scalar core and the vector coprocessor.
// Carries each vector instruction with its rs1 operand, first-word fall-through.
module v_issue_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WORD_WIDTH-1:0]    in_instr,
  input  logic [WORD_WIDTH-1:0]    in_scalar,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [WORD_WIDTH-1:0]    out_instr,
  output logic [WORD_WIDTH-1:0]    out_scalar,
  input  logic                     out_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     illegal_instr,
  output logic [15:0]              issued_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [6:0] OP_V     = 7'h57;
  localparam logic [6:0] LOAD_FP  = 7'h07;
  localparam logic [6:0] STORE_FP = 7'h27;

  logic [WORD_WIDTH-1:0] instr_mem  [DEPTH];
  logic [WORD_WIDTH-1:0] scalar_mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  logic legal;
  logic push;
  logic pop;
  logic reject;

  // Status and head view come only from registered state; no ready/valid loop-through.
  always_comb begin
    legal      = (in_instr[6:0] == OP_V) || (in_instr[6:0] == LOAD_FP) ||
                 (in_instr[6:0] == STORE_FP);
    in_ready   = (count < CNT_W'(DEPTH));
    out_valid  = (count != '0);
    out_instr  = out_valid ? instr_mem[rd_ptr]  : '0;
    out_scalar = out_valid ? scalar_mem[rd_ptr] : '0;
    // Flush squashes every transfer in its cycle, including the illegal flag.
    push       = in_valid & in_ready & legal & ~flush;
    pop        = out_valid & out_ready & ~flush;
    reject     = in_valid & in_ready & ~legal & ~flush;
  end

  // Entry storage needs no reset: contents are masked by count when empty.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr]  <= in_instr;
      scalar_mem[wr_ptr] <= in_scalar;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      illegal_instr <= 1'b0;
      issued_cnt    <= '0;
    end else begin
      illegal_instr <= reject;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        // DEPTH is a power of two, so pointer wrap is the natural rollover.
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
      if (pop) issued_cnt <= issued_cnt + 16'd1;
    end
  end

endmodule
